// File: rtl/busca_pkg.sv
// Shared definitions for the instruction-fetch stage: default parameters,
// the layout of one prefetch-queue entry and the queue occupancy states.
package busca_pkg;

   localparam int          PROFUNDIDADE_PADRAO = 4;
   localparam logic [31:0] PC_RESET_PADRAO     = 32'h0000_0000;
   localparam logic [31:0] PC_INCREMENTO       = 32'd4;

   // One queue entry: fetch address in the upper half, fetched word in the lower half.
   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instrucao;
   } entrada_t;

   // Coarse occupancy of the prefetch queue.
   typedef enum logic [1:0] {
      VAZIO   = 2'd0,
      PARCIAL = 2'd1,
      CHEIO   = 2'd2
   } ocupacao_e;

   // Forces an address onto a word boundary.
   function automatic logic [31:0] alinha(input logic [31:0] endereco);
      return {endereco[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/fila_busca.sv
// Prefetch queue: synchronous FIFO of {pc, instrucao} entries with push,
// pop and flush. Registered storage, no write-to-read bypass, so a pushed
// entry is first visible at the head one cycle after it was written.
// PROFUNDIDADE must be a power of two and at least 2 so the pointers wrap
// naturally.
module fila_busca
   import busca_pkg::*;
#(
   parameter int PROFUNDIDADE = PROFUNDIDADE_PADRAO
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          flush,
   input  logic                          push,
   input  entrada_t                      dado_entrada,
   input  logic                          pop,
   output logic                          push_aceito,
   output logic                          valida,
   output entrada_t                      dado_saida,
   output logic [$clog2(PROFUNDIDADE):0] contagem
);

   localparam int LARG_PTR = $clog2(PROFUNDIDADE);
   localparam logic [LARG_PTR:0] CONT_CHEIA = PROFUNDIDADE[LARG_PTR:0];

   entrada_t            mem [PROFUNDIDADE];
   logic [LARG_PTR-1:0] wr_ptr;
   logic [LARG_PTR-1:0] rd_ptr;
   logic [LARG_PTR:0]   prox_contagem;
   ocupacao_e           estado;
   ocupacao_e           prox_estado;
   logic                cheia;
   logic                pop_aceito;

   // Status flags decode straight from the registered occupancy state.
   assign valida = (estado != VAZIO);
   assign cheia  = (estado == CHEIO);

   // A flush cancels both operations; a pop frees a slot for a same-cycle push.
   assign pop_aceito  = pop && valida && !flush;
   assign push_aceito = push && !flush && (!cheia || pop_aceito);

   // Head is forced to zero while empty so stale or uninitialised storage never leaks out.
   assign dado_saida = valida ? mem[rd_ptr] : '0;

   // Next occupancy count and state from this cycle's accepted push/pop.
   always_comb begin
      // NOTE: every always_comb output gets a default first, so no path can leave it unassigned and infer a latch.
      prox_contagem = contagem;
      prox_estado   = PARCIAL;
      if (push_aceito && !pop_aceito) begin
         prox_contagem = contagem + 1'b1;
      end else if (!push_aceito && pop_aceito) begin
         prox_contagem = contagem - 1'b1;
      end
      if (prox_contagem == '0) begin
         prox_estado = VAZIO;
      end else if (prox_contagem == CONT_CHEIA) begin
         prox_estado = CHEIO;
      end
   end

   // Pointer, count and occupancy-state registers; reset and flush empty the queue.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (reset || flush) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         contagem <= '0;
         estado   <= VAZIO;
      end else begin
         if (push_aceito) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop_aceito) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         contagem <= prox_contagem;
         estado   <= prox_estado;
      end
   end

   // Entry storage write port.
   always_ff @(posedge clk) begin
      // NOTE: the storage array is deliberately not reset; the empty-state output mask makes its contents unobservable.
      if (!reset && push_aceito) begin
         mem[wr_ptr] <= dado_entrada;
      end
   end

endmodule

// File: rtl/busca_instrucao.sv
// Instruction-fetch stage: owns the PC, drives the instruction-memory
// address and feeds fetched {pc, instrucao} pairs into the prefetch queue.
// A redirect (desvio) flushes the queue and reloads the PC with the
// word-aligned target; a stall (parar) holds the PC but lets the queue drain.
module busca_instrucao
   import busca_pkg::*;
#(
   parameter int          PROFUNDIDADE = PROFUNDIDADE_PADRAO,
   parameter logic [31:0] PC_RESET     = PC_RESET_PADRAO
) (
   input  logic                          clk,
   input  logic                          reset,
   output logic [31:0]                   endereco,
   input  logic [31:0]                   instrucao,
   input  logic                          desvio,
   input  logic [31:0]                   desvio_alvo,
   input  logic                          parar,
   output logic                          saida_valida,
   input  logic                          saida_pronta,
   output logic [31:0]                   saida_instrucao,
   output logic [31:0]                   saida_pc,
   output logic [$clog2(PROFUNDIDADE):0] ocupacao
);

   logic [31:0] pc;
   logic        pede_push;
   logic        push_aceito;
   entrada_t    entrada;
   entrada_t    cabeca;

   // Instruction memory is addressed directly by the PC; its word returns in the same cycle.
   assign endereco = pc;

   // A fetch is attempted whenever nothing redirects or stalls the stage;
   // the queue decides whether there is room for it.
   assign pede_push = !desvio && !parar;
   assign entrada   = '{pc: pc, instrucao: instrucao};

   fila_busca #(
      .PROFUNDIDADE (PROFUNDIDADE)
   ) u_fila (
      .clk          (clk),
      .reset        (reset),
      .flush        (desvio),
      .push         (pede_push),
      .dado_entrada (entrada),
      .pop          (saida_pronta),
      .push_aceito  (push_aceito),
      .valida       (saida_valida),
      .dado_saida   (cabeca),
      .contagem     (ocupacao)
   );

   assign saida_instrucao = cabeca.instrucao;
   assign saida_pc        = cabeca.pc;

   // PC register: reset, then redirect, then sequential advance on an accepted fetch (wraps modulo 2^32).
   always_ff @(posedge clk) begin
      if (reset) begin
         pc <= alinha(PC_RESET);
      end else if (desvio) begin
         pc <= alinha(desvio_alvo);
      end else if (push_aceito) begin
         pc <= pc + PC_INCREMENTO;
      end
   end

endmodule

// File: tb/tb_busca_instrucao.sv
// Bench for busca_instrucao: a directed vector table for streaming,
// backpressure, redirect, stall and reset, a hand-written address-wrap
// sequence on a second instance, and randomized traffic checked against a
// queue-based reference model.
module tb_busca_instrucao;
   import busca_pkg::*;

   localparam int P = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int aplicados = 0;
   int erros     = 0;

   // Main instance, PC_RESET = 0
   logic        reset, desvio, parar, saida_pronta, saida_valida;
   logic [31:0] endereco, instrucao, desvio_alvo, saida_instrucao, saida_pc;
   logic [2:0]  ocupacao;

   // Wrap instance, PC_RESET = FFFFFFF8
   logic        w_reset, w_desvio, w_parar, w_pronta, w_valida;
   logic [31:0] w_endereco, w_instrucao, w_alvo, w_sinstr, w_spc;
   logic [2:0]  w_ocupacao;

   // Instruction memory contents: an address-dependent pattern.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
   endfunction

   assign instrucao   = mem_word(endereco);
   assign w_instrucao = mem_word(w_endereco);

   busca_instrucao #(.PROFUNDIDADE(P), .PC_RESET(32'h0000_0000)) dut (
      .clk(clk), .reset(reset), .endereco(endereco), .instrucao(instrucao),
      .desvio(desvio), .desvio_alvo(desvio_alvo), .parar(parar),
      .saida_valida(saida_valida), .saida_pronta(saida_pronta),
      .saida_instrucao(saida_instrucao), .saida_pc(saida_pc), .ocupacao(ocupacao)
   );

   busca_instrucao #(.PROFUNDIDADE(P), .PC_RESET(32'hFFFF_FFF8)) dut_wrap (
      .clk(clk), .reset(w_reset), .endereco(w_endereco), .instrucao(w_instrucao),
      .desvio(w_desvio), .desvio_alvo(w_alvo), .parar(w_parar),
      .saida_valida(w_valida), .saida_pronta(w_pronta),
      .saida_instrucao(w_sinstr), .saida_pc(w_spc), .ocupacao(w_ocupacao)
   );

   task automatic check(input string nome, input logic [31:0] atual, input logic [31:0] esperado);
      aplicados++;
      if (atual !== esperado) begin
         erros++;
         $display("FAIL %s: got %h, expected %h", nome, atual, esperado);
      end
   endtask

   // Directed vectors: inputs held across one rising edge, outputs expected just after it.
   typedef struct {
      logic        rst;
      logic        dsv;
      logic [31:0] alvo;
      logic        par;
      logic        pro;
      int          e_ocup;
      logic        e_val;
      logic [31:0] e_end;
      logic [31:0] e_spc;
   } vetor_t;

   vetor_t tabela[$];

   function automatic vetor_t v(logic r, logic d, logic [31:0] a, logic p, logic pr,
                                int oc, logic vl, logic [31:0] en, logic [31:0] sp);
      vetor_t x;
      x.rst = r; x.dsv = d; x.alvo = a; x.par = p; x.pro = pr;
      x.e_ocup = oc; x.e_val = vl; x.e_end = en; x.e_spc = sp;
      return x;
   endfunction

   // Reference model: PC plus a plain queue of fetched entries.
   logic [31:0] m_pc;
   entrada_t    m_fila[$];

   task automatic modelo_passo();
      bit faz_pop, faz_push;
      if (reset) begin
         m_fila.delete();
         m_pc = 32'h0000_0000;
      end else if (desvio) begin
         m_fila.delete();
         m_pc = desvio_alvo & 32'hFFFF_FFFC;
      end else begin
         faz_pop  = (m_fila.size() > 0) && saida_pronta;
         faz_push = !parar && ((m_fila.size() < P) || faz_pop);
         if (faz_pop) void'(m_fila.pop_front());
         if (faz_push) begin
            m_fila.push_back('{pc: m_pc, instrucao: mem_word(m_pc)});
            m_pc = m_pc + 32'd4;
         end
      end
   endtask

   task automatic compara(input int ciclo);
      logic        e_val;
      logic [31:0] e_spc, e_ins;
      e_val = (m_fila.size() > 0);
      e_spc = e_val ? m_fila[0].pc : 32'h0;
      e_ins = e_val ? m_fila[0].instrucao : 32'h0;
      check($sformatf("rnd%0d endereco", ciclo), endereco, m_pc);
      check($sformatf("rnd%0d ocupacao", ciclo), 32'(ocupacao), 32'(m_fila.size()));
      check($sformatf("rnd%0d valida", ciclo), 32'(saida_valida), 32'(e_val));
      check($sformatf("rnd%0d saida_pc", ciclo), saida_pc, e_spc);
      check($sformatf("rnd%0d saida_instrucao", ciclo), saida_instrucao, e_ins);
   endtask

   initial begin
      reset = 1'b1; desvio = 1'b0; desvio_alvo = '0; parar = 1'b0; saida_pronta = 1'b0;
      w_reset = 1'b1; w_desvio = 1'b0; w_alvo = '0; w_parar = 1'b0; w_pronta = 1'b1;

      // Address wrap: FFFFFFF8, FFFFFFFC, 00000000 at the head on consecutive cycles.
      @(posedge clk); #1;
      check("wrap reset endereco", w_endereco, 32'hFFFF_FFF8);
      check("wrap reset valida", 32'(w_valida), 32'd0);
      w_reset = 1'b0;
      @(posedge clk); #1;
      check("wrap spc0", w_spc, 32'hFFFF_FFF8);
      check("wrap ins0", w_sinstr, mem_word(32'hFFFF_FFF8));
      @(posedge clk); #1;
      check("wrap spc1", w_spc, 32'hFFFF_FFFC);
      check("wrap endereco wrapped", w_endereco, 32'h0000_0000);
      @(posedge clk); #1;
      check("wrap spc2", w_spc, 32'h0000_0000);
      check("wrap ins2", w_sinstr, mem_word(32'h0000_0000));

      // Streaming from reset
      tabela.push_back(v(1,0,0,0,0, 0,0,32'h00,32'h00));
      tabela.push_back(v(0,0,0,0,1, 1,1,32'h04,32'h00));
      tabela.push_back(v(0,0,0,0,1, 1,1,32'h08,32'h04));
      tabela.push_back(v(0,0,0,0,1, 1,1,32'h0C,32'h08));
      tabela.push_back(v(0,0,0,0,1, 1,1,32'h10,32'h0C));
      tabela.push_back(v(0,0,0,0,1, 1,1,32'h14,32'h10));
      // Backpressure: 10 cycles without pronta, then resume (full + pop keeps ocupacao at 4)
      tabela.push_back(v(1,0,0,0,1, 0,0,32'h00,32'h00));
      tabela.push_back(v(0,0,0,0,0, 1,1,32'h04,32'h00));
      tabela.push_back(v(0,0,0,0,0, 2,1,32'h08,32'h00));
      tabela.push_back(v(0,0,0,0,0, 3,1,32'h0C,32'h00));
      for (int i = 0; i < 7; i++) tabela.push_back(v(0,0,0,0,0, 4,1,32'h10,32'h00));
      tabela.push_back(v(0,0,0,0,1, 4,1,32'h14,32'h04));
      tabela.push_back(v(0,0,0,0,1, 4,1,32'h18,32'h08));
      tabela.push_back(v(0,0,0,0,1, 4,1,32'h1C,32'h0C));
      tabela.push_back(v(0,0,0,0,1, 4,1,32'h20,32'h10));
      // Redirect at ocupacao=3, then pop+redirect to a misaligned target
      tabela.push_back(v(1,0,0,0,0, 0,0,32'h00,32'h00));
      tabela.push_back(v(0,0,0,0,0, 1,1,32'h04,32'h00));
      tabela.push_back(v(0,0,0,0,0, 2,1,32'h08,32'h00));
      tabela.push_back(v(0,0,0,0,0, 3,1,32'h0C,32'h00));
      tabela.push_back(v(0,1,32'h40,0,0, 0,0,32'h40,32'h00));
      tabela.push_back(v(0,0,0,0,1, 1,1,32'h44,32'h40));
      tabela.push_back(v(0,1,32'h43,0,1, 0,0,32'h40,32'h00));
      tabela.push_back(v(0,0,0,0,0, 1,1,32'h44,32'h40));
      // Fill to 3, stall for 3 cycles while draining, then reset mid-stream
      tabela.push_back(v(0,0,0,0,0, 2,1,32'h48,32'h40));
      tabela.push_back(v(0,0,0,0,0, 3,1,32'h4C,32'h40));
      tabela.push_back(v(0,0,0,1,1, 2,1,32'h4C,32'h44));
      tabela.push_back(v(0,0,0,1,1, 1,1,32'h4C,32'h48));
      tabela.push_back(v(0,0,0,1,1, 0,0,32'h4C,32'h00));
      tabela.push_back(v(0,0,0,0,1, 1,1,32'h50,32'h4C));
      tabela.push_back(v(0,0,0,0,1, 1,1,32'h54,32'h50));
      tabela.push_back(v(1,1,32'h80,1,1, 0,0,32'h00,32'h00));
      tabela.push_back(v(0,0,0,0,1, 1,1,32'h04,32'h00));

      for (int i = 0; i < tabela.size(); i++) begin
         reset        = tabela[i].rst;
         desvio       = tabela[i].dsv;
         desvio_alvo  = tabela[i].alvo;
         parar        = tabela[i].par;
         saida_pronta = tabela[i].pro;
         @(posedge clk); #1;
         check($sformatf("v%0d ocupacao", i), 32'(ocupacao), 32'(tabela[i].e_ocup));
         check($sformatf("v%0d valida", i), 32'(saida_valida), 32'(tabela[i].e_val));
         check($sformatf("v%0d endereco", i), endereco, tabela[i].e_end);
         check($sformatf("v%0d saida_pc", i), saida_pc, tabela[i].e_spc);
         check($sformatf("v%0d saida_instrucao", i), saida_instrucao,
               tabela[i].e_val ? mem_word(tabela[i].e_spc) : 32'h0);
      end

      // Randomized traffic against the reference model; the first cycle resets both.
      for (int c = 0; c < 3000; c++) begin
         reset        = (c == 0) || ($urandom_range(0, 199) == 0);
         desvio       = ($urandom_range(0, 99) < 5);
         desvio_alvo  = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | $urandom_range(0, 15)) : $urandom;
         parar        = ($urandom_range(0, 99) < 20);
         saida_pronta = ($urandom_range(0, 99) < 60);
         @(posedge clk);
         modelo_passo();
         #1;
         compara(c);
      end

      $display("== %0d vectors applied, %0d miscompares ==", aplicados, erros);
      $finish;
   end

endmodule
